// File: rtl/billing_pkg.sv
// Shared types, constants and helpers for the washing-machine billing block.
package billing_pkg;

  localparam int unsigned BCD_W = 12;
  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;

  localparam logic [1:0] MODE_DRY   = 2'd0;
  localparam logic [1:0] MODE_SMALL = 2'd1;
  localparam logic [1:0] MODE_MED   = 2'd2;
  localparam logic [1:0] MODE_BIG   = 2'd3;

  // Clamp every BCD digit above 9 down to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/billing_if.sv
// Admin/customer-side signal bundle for the billing block.
interface billing_if;
  import billing_pkg::*;

  logic [1:0]       mode_sel;
  logic             start;
  logic             done;
  logic             pickup;
  logic [BCD_W-1:0] dy_price;
  logic [BCD_W-1:0] s_price;
  logic [BCD_W-1:0] m_price;
  logic [BCD_W-1:0] b_price;
  logic [BCD_W-1:0] setfine;
  logic             profit_load;
  logic [BCD_W-1:0] profit_in;
  logic             time_rst;
  logic [BCD_W-1:0] profit;
  logic [BCD_W-1:0] runtime;
  logic [BCD_W-1:0] charge;
  logic             busy;
  logic             paid;

  modport master (
    output mode_sel, start, done, pickup, dy_price, s_price, m_price, b_price,
           setfine, profit_load, profit_in, time_rst,
    input  profit, runtime, charge, busy, paid
  );

  modport slave (
    input  mode_sel, start, done, pickup, dy_price, s_price, m_price, b_price,
           setfine, profit_load, profit_in, time_rst,
    output profit, runtime, charge, busy, paid
  );
endinterface

// File: rtl/bcd3_add_sat.sv
// Combinational 3-digit packed-BCD adder; any carry out of hundreds saturates to 999.
module bcd3_add_sat
  import billing_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  output logic [BCD_W-1:0] sum_o
);

  logic [4:0]       dsum;
  logic             carry;
  logic [BCD_W-1:0] raw;

  always_comb begin
    dsum  = '0;
    carry = 1'b0;
    raw   = '0;
    for (int i = 0; i < 3; i++) begin
      dsum = 5'(a_i[4*i +: 4]) + 5'(b_i[4*i +: 4]) + 5'(carry);
      if (dsum > 5'd9) begin
        raw[4*i +: 4] = 4'(dsum - 5'd10);
        carry         = 1'b1;
      end else begin
        raw[4*i +: 4] = dsum[3:0];
        carry         = 1'b0;
      end
    end
    sum_o = carry ? BCD_MAX : raw;
  end

endmodule

// File: rtl/billing.sv
// Order settlement: latches the mode price, accrues overdue fines, books profit
// on pickup and keeps the BCD runtime counter.
module billing
  import billing_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned GRACE_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst,
  billing_if.slave  bus
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned OW = $clog2(GRACE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [OW-1:0] OVD_LAST   = OW'(GRACE_TICKS - 1);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [OW-1:0]    ovd_q, ovd_d;
  logic [BCD_W-1:0] charge_q, charge_d;
  logic [BCD_W-1:0] profit_q, profit_d;
  logic [BCD_W-1:0] runtime_q, runtime_d;
  logic             busy_q, busy_d;
  logic             paid_q, paid_d;

  logic             tick_c;
  logic [BCD_W-1:0] price_c;
  logic [BCD_W-1:0] profit_base_c;
  logic [BCD_W-1:0] fine_sum_c;
  logic [BCD_W-1:0] profit_sum_c;
  logic [BCD_W-1:0] runtime_sum_c;

  assign tick_c        = (presc_q == PRESC_LAST);
  // An admin write in the settle cycle replaces the base the bill is added to.
  assign profit_base_c = bus.profit_load ? bus.profit_in : profit_q;

  bcd3_add_sat u_fine_add    (.a_i(charge_q),      .b_i(bus.setfine), .sum_o(fine_sum_c));
  bcd3_add_sat u_profit_add  (.a_i(profit_base_c), .b_i(charge_q),    .sum_o(profit_sum_c));
  bcd3_add_sat u_runtime_add (.a_i(runtime_q),     .b_i(12'h001),     .sum_o(runtime_sum_c));

  always_comb begin
    price_c = bus.dy_price;
    case (bus.mode_sel)
      MODE_DRY:   price_c = bus.dy_price;
      MODE_SMALL: price_c = bus.s_price;
      MODE_MED:   price_c = bus.m_price;
      MODE_BIG:   price_c = bus.b_price;
      default:    price_c = bus.dy_price;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    charge_d  = charge_q;
    profit_d  = profit_q;
    runtime_d = runtime_q;
    ovd_d     = ovd_q;
    presc_d   = tick_c ? '0 : presc_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          charge_d = bcd_clamp(price_c);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.done) begin
          ovd_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.pickup) begin
          state_d = S_SETTLE;
        end else if (tick_c) begin
          if (ovd_q == OVD_LAST) begin
            charge_d = fine_sum_c;
            ovd_d    = '0;
          end else begin
            ovd_d = ovd_q + OW'(1);
          end
        end
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_q == S_SETTLE)  profit_d = profit_sum_c;
    else if (bus.profit_load) profit_d = bus.profit_in;

    if (bus.time_rst)                     runtime_d = '0;
    else if (state_q == S_RUN && tick_c)  runtime_d = runtime_sum_c;

    busy_d = (state_d != S_IDLE);
    paid_d = (state_d == S_SETTLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ovd_q     <= '0;
      charge_q  <= '0;
      profit_q  <= '0;
      runtime_q <= '0;
      busy_q    <= 1'b0;
      paid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ovd_q     <= ovd_d;
      charge_q  <= charge_d;
      profit_q  <= profit_d;
      runtime_q <= runtime_d;
      busy_q    <= busy_d;
      paid_q    <= paid_d;
    end
  end

  assign bus.profit  = profit_q;
  assign bus.runtime = runtime_q;
  assign bus.charge  = charge_q;
  assign bus.busy    = busy_q;
  assign bus.paid    = paid_q;

endmodule

// File: tb/tb_billing.sv
// Directed bench for billing: a vector table for price selection plus
// hand-written sequences for fines, saturation, collisions, runtime and reset.
module tb_billing;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0]  tb_presc;
  logic [11:0] exp_profit;

  always #5 clk = ~clk;

  billing_if bus ();

  billing #(.TICK_CYCLES(4), .GRACE_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference prescaler: tick edge is the one that samples tb_presc == 3.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_presc <= 2'd0;
    else     tb_presc <= (tb_presc == 2'd3) ? 2'd0 : tb_presc + 2'd1;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] dy, s, m, b;
    logic        with_done;
    logic [11:0] exp_charge;
  } vec_t;

  vec_t vecs [5];

  function automatic int bcd2i(input logic [11:0] v);
    return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] sat_model(input logic [11:0] a, input logic [11:0] b);
    int s;
    s = bcd2i(a) + bcd2i(b);
    if (s > 999) s = 999;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_wait(input int n);
    int seen;
    seen = 0;
    for (int g = 0; g < n * 8 + 8 && seen < n; g++) begin
      if (tb_presc == 2'd3) seen++;
      step();
    end
  endtask

  task automatic align_tick();
    for (int g = 0; g < 8 && tb_presc != 2'd3; g++) step();
  endtask

  task automatic load_profit(input logic [11:0] v);
    bus.profit_load = 1'b1;
    bus.profit_in   = v;
    step();
    bus.profit_load = 1'b0;
    check("profit_load", bus.profit, v);
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    bus.mode_sel = mode;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
  endtask

  task automatic pulse_pickup();
    bus.pickup = 1'b1;
    step();
    bus.pickup = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode_sel = 2'd0; bus.start = 1'b0; bus.done = 1'b0; bus.pickup = 1'b0;
    bus.dy_price = '0; bus.s_price = '0; bus.m_price = '0; bus.b_price = '0;
    bus.setfine = '0; bus.profit_load = 1'b0; bus.profit_in = '0; bus.time_rst = 1'b0;

    vecs[0] = '{mode: 2'd2, dy: 12'h011, s: 12'h012, m: 12'h025, b: 12'h040, with_done: 1'b0, exp_charge: 12'h025};
    vecs[1] = '{mode: 2'd0, dy: 12'h011, s: 12'h012, m: 12'h025, b: 12'h040, with_done: 1'b1, exp_charge: 12'h011};
    vecs[2] = '{mode: 2'd1, dy: 12'h011, s: 12'h012, m: 12'h025, b: 12'h040, with_done: 1'b0, exp_charge: 12'h012};
    vecs[3] = '{mode: 2'd3, dy: 12'h011, s: 12'h012, m: 12'h025, b: 12'h0C4, with_done: 1'b0, exp_charge: 12'h094};
    vecs[4] = '{mode: 2'd1, dy: 12'h011, s: 12'hFAB, m: 12'h025, b: 12'h040, with_done: 1'b0, exp_charge: 12'h999};

    repeat (2) @(posedge clk);
    #1;
    check("rst_profit",  bus.profit,  12'h000);
    check("rst_runtime", bus.runtime, 12'h000);
    check("rst_charge",  bus.charge,  12'h000);
    check("rst_busy",    12'(bus.busy), 12'h000);
    check("rst_paid",    12'(bus.paid), 12'h000);
    rst = 1'b0;
    exp_profit = 12'h000;

    // Price selection and clamp table.
    for (int i = 0; i < 5; i++) begin
      bus.dy_price = vecs[i].dy; bus.s_price = vecs[i].s;
      bus.m_price  = vecs[i].m;  bus.b_price = vecs[i].b;
      bus.done     = vecs[i].with_done;
      pulse_start(vecs[i].mode);
      bus.done     = 1'b0;
      bus.mode_sel = ~vecs[i].mode;
      bus.dy_price = 12'h888; bus.s_price = 12'h888; bus.m_price = 12'h888; bus.b_price = 12'h888;
      check("vec_charge", bus.charge, vecs[i].exp_charge);
      check("vec_busy", 12'(bus.busy), 12'h001);
      if (vecs[i].with_done) begin
        pulse_pickup();
        check("start_done_ignored_paid", 12'(bus.paid), 12'h000);
        check("start_done_ignored_busy", 12'(bus.busy), 12'h001);
      end
      pulse_done();
      pulse_pickup();
      check("vec_paid", 12'(bus.paid), 12'h001);
      check("vec_settle_charge", bus.charge, vecs[i].exp_charge);
      step();
      exp_profit = sat_model(exp_profit, vecs[i].exp_charge);
      check("vec_paid_clear", 12'(bus.paid), 12'h000);
      check("vec_busy_clear", 12'(bus.busy), 12'h000);
      check("vec_profit", bus.profit, exp_profit);
      check("vec_charge_hold", bus.charge, vecs[i].exp_charge);
    end

    // Fine accrual: 7 waiting ticks give two fine steps.
    load_profit(12'h000);
    bus.setfine = 12'h005; bus.b_price = 12'h040;
    pulse_start(2'd3);
    pulse_done();
    bus.b_price = 12'h077;
    tick_wait(7);
    pulse_pickup();
    check("fine_charge", bus.charge, 12'h050);
    step();
    check("fine_profit", bus.profit, 12'h050);

    // Profit saturation.
    load_profit(12'h990);
    bus.m_price = 12'h015;
    pulse_start(2'd2);
    pulse_done();
    pulse_pickup();
    step();
    check("sat_profit", bus.profit, 12'h999);

    // profit_load coinciding with SETTLE.
    bus.s_price = 12'h030;
    pulse_start(2'd1);
    pulse_done();
    pulse_pickup();
    bus.profit_load = 1'b1; bus.profit_in = 12'h000;
    step();
    bus.profit_load = 1'b0;
    check("load_settle_profit", bus.profit, 12'h030);

    // Pickup on the fine-step tick: no fine.
    load_profit(12'h000);
    bus.setfine = 12'h005; bus.b_price = 12'h040;
    pulse_start(2'd3);
    pulse_done();
    tick_wait(2);
    align_tick();
    pulse_pickup();
    check("pickup_tick_charge", bus.charge, 12'h040);
    step();
    check("pickup_tick_profit", bus.profit, 12'h040);

    // start during RUN is ignored.
    bus.m_price = 12'h020; bus.b_price = 12'h050;
    pulse_start(2'd2);
    check("run_start_charge0", bus.charge, 12'h020);
    pulse_start(2'd3);
    check("run_start_ignored", bus.charge, 12'h020);
    pulse_done();
    pulse_pickup();
    step();

    // Runtime counting.
    bus.time_rst = 1'b1;
    step();
    bus.time_rst = 1'b0;
    check("runtime_clr", bus.runtime, 12'h000);
    pulse_start(2'd1);
    tick_wait(5);
    check("runtime_5", bus.runtime, 12'h005);
    align_tick();
    pulse_done();
    check("runtime_done_tick", bus.runtime, 12'h006);
    tick_wait(3);
    check("runtime_wait_hold", bus.runtime, 12'h006);
    pulse_pickup();
    step();
    tick_wait(2);
    check("runtime_idle_hold", bus.runtime, 12'h006);
    pulse_start(2'd1);
    tick_wait(1);
    check("runtime_7", bus.runtime, 12'h007);
    bus.time_rst = 1'b1;
    tick_wait(1);
    check("runtime_rst_prio", bus.runtime, 12'h000);
    bus.time_rst = 1'b0;
    pulse_done();
    pulse_pickup();
    step();

    // Reset mid-WAIT discards the order.
    load_profit(12'h000);
    bus.m_price = 12'h045;
    pulse_start(2'd2);
    pulse_done();
    check("mid_wait_charge", bus.charge, 12'h045);
    check("mid_wait_busy", 12'(bus.busy), 12'h001);
    #2 rst = 1'b1;
    #1;
    check("async_rst_charge",  bus.charge,  12'h000);
    check("async_rst_profit",  bus.profit,  12'h000);
    check("async_rst_runtime", bus.runtime, 12'h000);
    check("async_rst_busy",    12'(bus.busy), 12'h000);
    step();
    rst = 1'b0;
    pulse_pickup();
    step();
    check("post_rst_paid",   12'(bus.paid), 12'h000);
    check("post_rst_busy",   12'(bus.busy), 12'h000);
    check("post_rst_profit", bus.profit, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/billing.md
# billing

Customer-side settlement block for the washing machine: the reader of the price and fine registers that the admin mode writes. It latches the price for the selected wash mode on order start and accrues the overdue fine while washed laundry waits for pickup. On pickup it adds the bill to the running BCD profit; it also keeps the BCD runtime counter that the admin mode displays and clears. All money and time values are 3-digit packed BCD ({hundreds, tens, ones}), 12 bits wide.

## Interface
- TICK_CYCLES, 100_000_000, clk cycles per time tick (1 s at 100 MHz)
- GRACE_TICKS, 10, waiting ticks per fine step (first fine after GRACE_TICKS ticks, then every GRACE_TICKS ticks)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode_sel  in  2  wash mode: 0 dry, 1 small, 2 medium, 3 big
- start  in  1  one-cycle pulse, order begins
- done  in  1  one-cycle pulse, wash cycle finished
- pickup  in  1  one-cycle pulse, laundry collected
- dy_price, s_price, m_price, b_price  in  12 each  BCD prices per mode
- setfine  in  12  BCD fine per fine step
- profit_load  in  1  one-cycle pulse, load profit_in (admin write-back)
- profit_in  in  12  BCD profit value from admin
- time_rst  in  1  level, clears runtime while high
- profit  out  12  BCD accumulated income
- runtime  out  12  BCD ticks spent in RUN
- charge  out  12  BCD bill of the current order
- busy  out  1  high in every state except IDLE
- paid  out  1  one-cycle pulse in SETTLE

## Operation
- States: IDLE, RUN, WAIT, SETTLE.
- IDLE:
  - start → charge <= price selected by mode_sel (mode 0 dy_price, 1 s_price, 2 m_price, 3 b_price); go to RUN.
  - Each latched BCD digit above 9 is clamped to 9.
- RUN: done → WAIT; overdue tick counter cleared.
- WAIT:
  - Overdue counter increments on each tick.
  - When it reaches GRACE_TICKS: charge <= sat(charge + setfine), counter cleared.
  - pickup → SETTLE.
- SETTLE (exactly one cycle): profit <= sat(profit + charge); paid = 1; go to IDLE. charge holds its value until the next start.
- Price inputs are sampled only at start. Admin changes during RUN or WAIT do not affect the current order. setfine is sampled at each fine step.
- Runtime:
  - Increments by 1 (BCD) on each tick while in RUN; saturates at 999.
  - time_rst high → runtime <= 0; this has priority over increment.
- profit_load → profit <= profit_in. If it coincides with SETTLE: profit <= sat(profit_in + charge).
- sat(): 3-digit BCD add with a 999 ceiling. Any carry out of hundreds yields 12'h999.
- Ignored inputs:
  - start outside IDLE.
  - done outside RUN.
  - pickup outside WAIT.
  - mode_sel outside the start cycle.

## Timing
- Reset values: state IDLE; profit, runtime and charge 12'h000; busy 0; paid 0; prescaler 0; overdue counter 0.
- Reset mid-order discards the order. No partial profit is credited.
- Tick: a one-cycle strobe when the free-running prescaler wraps at TICK_CYCLES-1. The prescaler runs in all states and is not restarted by start.
- Outputs are registered. charge is valid the cycle after the start cycle, and busy rises in that same cycle.
- pickup at cycle n → SETTLE in n+1 with paid = 1 → profit updated and busy = 0 in n+2.
- Simultaneous events:
  - pickup and a fine-step tick in the same cycle: pickup wins and no fine is added.
  - done and a tick in the same cycle: runtime still counts that tick.
  - start and done in the same cycle in IDLE: start is accepted and done is ignored.

## Structure
- billing_pkg holds:
  - the state enum;
  - mode codes MODE_DRY/SMALL/MED/BIG;
  - BCD_MAX = 12'h999;
  - the BCD digit-clamp function.
- Sub-module bcd3_add_sat is combinational: 3-digit BCD add saturating at 999. It is instantiated for the fine accumulation, the profit accumulation and the runtime increment (addend 12'h001).
- Prescaler and overdue counter are inline counters in billing.

## Test plan
Bench uses TICK_CYCLES=4, GRACE_TICKS=3.
- Mode select: m_price=12'h025, mode_sel=2, start; then done; then pickup before 3 ticks → charge 025, paid pulses once, profit 000→025.
- Fine accrual: b_price=12'h040, setfine=12'h005, mode 3, start, done; wait 7 ticks; pickup → 2 fine steps, charge 050, profit +050.
- Saturation and clamp:
  - profit preloaded to 12'h990 via profit_load, charge 12'h015 → profit 999.
  - Price digit 4'hC on start → latched as 9.
- Runtime:
  - 5 ticks in RUN → runtime 005.
  - Holding time_rst during a tick → 000.
  - No increment in IDLE or WAIT.
- Collisions and protocol:
  - profit_load with profit_in=000 in the SETTLE cycle, charge 030 → profit 030.
  - pickup on the same cycle as a fine-step tick → no fine added.
  - start during RUN is ignored.
- Reset mid-WAIT with charge 045 → all outputs 0, state IDLE, profit unchanged at 000.
